// File: rtl/mbfb_pkg.sv
// Shared types for the multibank frame buffer: per-bank lifecycle state and
// overrun counter sizing.
package mbfb_pkg;

  typedef enum logic [1:0] {
    BANK_FREE     = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_READY    = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_t;

  localparam int OVR_CNT_W = 16;
  localparam logic [OVR_CNT_W-1:0] OVR_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/mbfb_bank_ram.sv
// Simple dual-port RAM holding all banks back to back; address is {bank, offset}.
// Read port is registered; only the output register is reset, never the array.
module mbfb_bank_ram
  import mbfb_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iWR_EN,
  input  logic [ADDR_W-1:0] iWR_ADDR,
  input  logic [DATA_W-1:0] iWR_DATA,
  input  logic              iRD_EN,
  input  logic [ADDR_W-1:0] iRD_ADDR,
  output logic [DATA_W-1:0] oRD_DATA
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge iCLK) begin
    if (iWR_EN) mem[iWR_ADDR] <= iWR_DATA;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) oRD_DATA <= '0;
    else if (iRD_EN) oRD_DATA <= mem[iRD_ADDR];
  end

endmodule

// File: rtl/multibank_frame_buffer.sv
// Frame buffer with BANK_NUM independently committed banks drained in commit order.
// Define MBFB_OVERRUN_CNT_EN to build the saturating dropped-word counter.
module multibank_frame_buffer
  import mbfb_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int BANK_DEPTH = 512,
  parameter int BANK_NUM   = 2,
  parameter int CNT_W      = $clog2(BANK_DEPTH) + 1
) (
  input  logic                        iCLK,
  input  logic                        iRST,
  input  logic                        iWR_REQ,
  input  logic [DATA_W-1:0]           iDATA,
  input  logic                        iFRAME_END,
  input  logic                        iFRAME_ABORT,
  output logic                        oWR_FULL,
  output logic [$clog2(BANK_NUM)-1:0] oWR_BANK,
  input  logic                        iRD_REQ,
  output logic [DATA_W-1:0]           oDATA,
  output logic                        oRD_VALID,
  output logic                        oRD_EMPTY,
  output logic [$clog2(BANK_NUM)-1:0] oRD_BANK,
  output logic [CNT_W-1:0]            oRD_USEDW,
  output logic                        oFRAME_READY,
  output logic [OVR_CNT_W-1:0]        oOVERRUN_CNT
);

  localparam int BW = $clog2(BANK_NUM);
  localparam int AW = $clog2(BANK_DEPTH);

  // Handshake: a write is taken in any cycle with iWR_REQ=1 and oWR_FULL=0;
  // a read is taken in any cycle with iRD_REQ=1 and oRD_EMPTY=0, and its word
  // appears on oDATA with oRD_VALID=1 exactly one cycle later.
  bank_state_t      bankState [BANK_NUM];
  logic [CNT_W-1:0] bankLen   [BANK_NUM];
  logic [BW-1:0]    wrPtr, rdPtr, wrNext;
  logic [CNT_W-1:0] wrCnt, rdUsedw;
  logic             fillActive;

  logic             wrAccept, frameAbort, frameCommit;
  logic             rdAccept, lastRead;
  logic [CNT_W-1:0] commitLen, curUsedw;
  logic [AW-1:0]    rdOffset;

  // fillActive low means the committed-to bank was still occupied; wait for FREE.
  assign oWR_FULL = !fillActive || (wrCnt == CNT_W'(BANK_DEPTH));
  assign wrNext   = wrPtr + 1'b1;
  assign oWR_BANK = wrPtr;
  assign oRD_BANK = rdPtr;
  assign oRD_USEDW = curUsedw;

  always_comb begin
    wrAccept    = iWR_REQ && !oWR_FULL && !iFRAME_ABORT;
    frameAbort  = fillActive && iFRAME_ABORT;
    commitLen   = wrCnt + CNT_W'(wrAccept);
    frameCommit = fillActive && iFRAME_END && !iFRAME_ABORT && (commitLen != '0);

    oRD_EMPTY = !((bankState[rdPtr] == BANK_READY) || (bankState[rdPtr] == BANK_DRAINING));
    curUsedw  = '0;
    if (bankState[rdPtr] == BANK_DRAINING) curUsedw = rdUsedw;
    else if (bankState[rdPtr] == BANK_READY) curUsedw = bankLen[rdPtr];
    rdAccept = iRD_REQ && !oRD_EMPTY;
    rdOffset = AW'(bankLen[rdPtr] - curUsedw);
    lastRead = rdAccept && (curUsedw == CNT_W'(1));
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      for (int i = 0; i < BANK_NUM; i++) begin
        bankState[i] <= (i == 0) ? BANK_FILLING : BANK_FREE;
        bankLen[i]   <= '0;
      end
      wrPtr        <= '0;
      rdPtr        <= '0;
      wrCnt        <= '0;
      rdUsedw      <= '0;
      fillActive   <= 1'b1;
      oFRAME_READY <= 1'b0;
      oRD_VALID    <= 1'b0;
    end else begin
      oFRAME_READY <= frameCommit;
      oRD_VALID    <= rdAccept;

      if (!fillActive) begin
        if (bankState[wrPtr] == BANK_FREE) begin
          bankState[wrPtr] <= BANK_FILLING;
          fillActive       <= 1'b1;
          wrCnt            <= '0;
        end
      end else if (frameAbort) begin
        wrCnt <= '0;
      end else if (frameCommit) begin
        bankState[wrPtr] <= BANK_READY;
        bankLen[wrPtr]   <= commitLen;
        wrPtr            <= wrNext;
        wrCnt            <= '0;
        if (bankState[wrNext] == BANK_FREE) bankState[wrNext] <= BANK_FILLING;
        else fillActive <= 1'b0;
      end else if (wrAccept) begin
        wrCnt <= wrCnt + 1'b1;
      end

      // Read side only touches READY/DRAINING banks, so it never collides with the writer.
      if (rdAccept) begin
        if (lastRead) begin
          bankState[rdPtr] <= BANK_FREE;
          rdPtr            <= rdPtr + 1'b1;
          rdUsedw          <= '0;
        end else begin
          bankState[rdPtr] <= BANK_DRAINING;
          rdUsedw          <= curUsedw - 1'b1;
        end
      end else if (bankState[rdPtr] == BANK_READY) begin
        bankState[rdPtr] <= BANK_DRAINING;
        rdUsedw          <= bankLen[rdPtr];
      end
    end
  end

  mbfb_bank_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(BW + AW)
  ) uBankRam (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .iWR_EN   (wrAccept),
    .iWR_ADDR ({wrPtr, wrCnt[AW-1:0]}),
    .iWR_DATA (iDATA),
    .iRD_EN   (rdAccept),
    .iRD_ADDR ({rdPtr, rdOffset}),
    .oRD_DATA (oDATA)
  );

`ifdef MBFB_OVERRUN_CNT_EN
  logic [OVR_CNT_W-1:0] ovrCnt;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) ovrCnt <= '0;
    else if (iWR_REQ && oWR_FULL && (ovrCnt != OVR_CNT_MAX)) ovrCnt <= ovrCnt + 1'b1;
  end

  assign oOVERRUN_CNT = ovrCnt;
`else
  assign oOVERRUN_CNT = '0;
`endif

endmodule

// File: tb/tb_multibank_frame_buffer.sv
// Directed self-checking bench for multibank_frame_buffer (4 banks x 512 words).
// Overrun expectations follow MBFB_OVERRUN_CNT_EN.
module tb_multibank_frame_buffer;

  localparam int DATA_W     = 16;
  localparam int BANK_DEPTH = 512;
  localparam int BANK_NUM   = 4;
  localparam int CNT_W      = 10;

`ifdef MBFB_OVERRUN_CNT_EN
  localparam logic [15:0] OVR_TWO = 16'd2;
  localparam logic [15:0] OVR_ONE = 16'd1;
`else
  localparam logic [15:0] OVR_TWO = 16'd0;
  localparam logic [15:0] OVR_ONE = 16'd0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic iRST;
  always #5 clk = ~clk;

  logic              iWR_REQ, iFRAME_END, iFRAME_ABORT, iRD_REQ;
  logic [DATA_W-1:0] iDATA;
  logic              oWR_FULL, oRD_VALID, oRD_EMPTY, oFRAME_READY;
  logic [1:0]        oWR_BANK, oRD_BANK;
  logic [DATA_W-1:0] oDATA;
  logic [CNT_W-1:0]  oRD_USEDW;
  logic [15:0]       oOVERRUN_CNT;

  int checks   = 0;
  int failures = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [49:0] rst_exp;

  multibank_frame_buffer #(
    .DATA_W(DATA_W), .BANK_DEPTH(BANK_DEPTH), .BANK_NUM(BANK_NUM), .CNT_W(CNT_W)
  ) dut (
    .iCLK(clk), .iRST(iRST), .iWR_REQ(iWR_REQ), .iDATA(iDATA),
    .iFRAME_END(iFRAME_END), .iFRAME_ABORT(iFRAME_ABORT), .oWR_FULL(oWR_FULL),
    .oWR_BANK(oWR_BANK), .iRD_REQ(iRD_REQ), .oDATA(oDATA), .oRD_VALID(oRD_VALID),
    .oRD_EMPTY(oRD_EMPTY), .oRD_BANK(oRD_BANK), .oRD_USEDW(oRD_USEDW),
    .oFRAME_READY(oFRAME_READY), .oOVERRUN_CNT(oOVERRUN_CNT)
  );

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    iWR_REQ = 0; iDATA = '0; iFRAME_END = 0; iFRAME_ABORT = 0; iRD_REQ = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    iRST = 1;
    step();
    step();
    iRST = 0;
    step();
    exp_q.delete();
  endtask

  task automatic write_word(input logic [15:0] d, input logic fe, input bit push);
    iWR_REQ = 1; iDATA = d; iFRAME_END = fe;
    step();
    iWR_REQ = 0; iFRAME_END = 0;
    if (push) exp_q.push_back(d);
  endtask

  task automatic write_frame(input logic [15:0] base, input int len);
    for (int i = 0; i < len; i++) write_word(base + 16'(i), (i == len - 1), 1'b1);
  endtask

  // scoreboard pop happens here: each read must return the oldest queued word
  task automatic read_word(input string tag);
    logic [15:0] e;
    iRD_REQ = 1;
    step();
    iRD_REQ = 0;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    checks++;
    if (oRD_VALID !== 1'b1 || oDATA !== e) begin
      failures++;
      $display("FAIL %s_read: valid=%0b data=%h, want valid=1 data=%h", tag, oRD_VALID, oDATA, e);
    end
  endtask

  task automatic test_reset();
    iRST = 1;
    idle_inputs();
    #2;
    checks++;
    if ({oWR_FULL, oWR_BANK, oDATA, oRD_VALID, oRD_EMPTY, oRD_BANK, oRD_USEDW, oFRAME_READY, oOVERRUN_CNT} !== rst_exp) begin
      failures++;
      $display("FAIL reset_outputs: got %h want %h",
        {oWR_FULL, oWR_BANK, oDATA, oRD_VALID, oRD_EMPTY, oRD_BANK, oRD_USEDW, oFRAME_READY, oOVERRUN_CNT}, rst_exp);
    end
    do_reset();
  endtask

  task automatic test_basic_frame();
    do_reset();
    write_frame(16'h1000, 10);
    checks++;
    if (oFRAME_READY !== 1'b1 || oRD_EMPTY !== 1'b0 || oRD_USEDW !== 10'd10 || oWR_BANK !== 2'd1) begin
      failures++;
      $display("FAIL basic_commit: ready=%0b empty=%0b usedw=%0d wr_bank=%0d, want 1 0 10 1",
        oFRAME_READY, oRD_EMPTY, oRD_USEDW, oWR_BANK);
    end
    step();
    checks++;
    if (oFRAME_READY !== 1'b0 || oRD_USEDW !== 10'd10) begin
      failures++;
      $display("FAIL basic_pulse_end: ready=%0b usedw=%0d, want 0 10", oFRAME_READY, oRD_USEDW);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (oRD_USEDW !== 10'(10 - i)) begin
        failures++;
        $display("FAIL basic_usedw: got %0d want %0d", oRD_USEDW, 10 - i);
      end
      read_word("basic");
    end
    checks++;
    if (oRD_USEDW !== 10'd0 || oRD_EMPTY !== 1'b1 || oRD_BANK !== 2'd1) begin
      failures++;
      $display("FAIL basic_drained: usedw=%0d empty=%0b rd_bank=%0d, want 0 1 1", oRD_USEDW, oRD_EMPTY, oRD_BANK);
    end
    step();
    checks++;
    if (oRD_VALID !== 1'b0) begin
      failures++;
      $display("FAIL basic_valid_drop: got %0b want 0", oRD_VALID);
    end
  endtask

  task automatic test_four_banks();
    int lens[4];
    lens = '{3, 5, 7, 9};
    do_reset();
    for (int f = 0; f < 4; f++) write_frame(16'h2000 + 16'(f * 256), lens[f]);
    checks++;
    if (oWR_FULL !== 1'b1) begin
      failures++;
      $display("FAIL four_full: got %0b want 1", oWR_FULL);
    end
    write_word(16'hBAD0, 1'b0, 1'b0);
    write_word(16'hBAD1, 1'b0, 1'b0);
    checks++;
    if (oOVERRUN_CNT !== OVR_TWO || oWR_FULL !== 1'b1) begin
      failures++;
      $display("FAIL four_overrun: cnt=%0d full=%0b, want %0d 1", oOVERRUN_CNT, oWR_FULL, OVR_TWO);
    end
    for (int i = 0; i < 3; i++) read_word("four_f0");
    checks++;
    if (oWR_FULL !== 1'b1) begin
      failures++;
      $display("FAIL four_full_at_free: got %0b want 1", oWR_FULL);
    end
    step();
    checks++;
    if (oWR_FULL !== 1'b0 || oWR_BANK !== 2'd0) begin
      failures++;
      $display("FAIL four_full_release: full=%0b wr_bank=%0d, want 0 0", oWR_FULL, oWR_BANK);
    end
    for (int i = 0; i < 21; i++) read_word("four_rest");
    checks++;
    if (oRD_EMPTY !== 1'b1 || oRD_BANK !== 2'd0) begin
      failures++;
      $display("FAIL four_drained: empty=%0b rd_bank=%0d, want 1 0", oRD_EMPTY, oRD_BANK);
    end
  endtask

  task automatic test_full_bank();
    do_reset();
    for (int i = 0; i < BANK_DEPTH; i++) write_word(16'hC000 + 16'(i), 1'b0, 1'b1);
    checks++;
    if (oWR_FULL !== 1'b1) begin
      failures++;
      $display("FAIL full_at_depth: got %0b want 1", oWR_FULL);
    end
    write_word(16'hDEAD, 1'b0, 1'b0);
    checks++;
    if (oOVERRUN_CNT !== OVR_ONE) begin
      failures++;
      $display("FAIL full_overrun: got %0d want %0d", oOVERRUN_CNT, OVR_ONE);
    end
    iFRAME_END = 1;
    step();
    iFRAME_END = 0;
    checks++;
    if (oFRAME_READY !== 1'b1 || oRD_USEDW !== 10'd512) begin
      failures++;
      $display("FAIL full_commit: ready=%0b usedw=%0d, want 1 512", oFRAME_READY, oRD_USEDW);
    end
    for (int i = 0; i < BANK_DEPTH; i++) read_word("full");
    checks++;
    if (oRD_EMPTY !== 1'b1) begin
      failures++;
      $display("FAIL full_drained: empty=%0b want 1", oRD_EMPTY);
    end
  endtask

  task automatic test_abort();
    int pulses;
    pulses = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      write_word(16'h4000 + 16'(i), 1'b0, 1'b0);
      pulses += int'(oFRAME_READY);
    end
    iWR_REQ = 1; iDATA = 16'hEEEE; iFRAME_END = 1; iFRAME_ABORT = 1;
    step();
    idle_inputs();
    pulses += int'(oFRAME_READY);
    for (int i = 0; i < 4; i++) begin
      write_word(16'h4100 + 16'(i), (i == 3), 1'b1);
      pulses += int'(oFRAME_READY);
    end
    step();
    pulses += int'(oFRAME_READY);
    checks++;
    if (pulses != 1 || oRD_USEDW !== 10'd4) begin
      failures++;
      $display("FAIL abort_frame: pulses=%0d usedw=%0d, want 1 4", pulses, oRD_USEDW);
    end
    for (int i = 0; i < 4; i++) read_word("abort");
  endtask

  task automatic test_empty_ops();
    do_reset();
    iFRAME_END = 1;
    step();
    iFRAME_END = 0;
    checks++;
    if (oFRAME_READY !== 1'b0 || oWR_BANK !== 2'd0 || oRD_EMPTY !== 1'b1) begin
      failures++;
      $display("FAIL empty_commit: ready=%0b wr_bank=%0d empty=%0b, want 0 0 1", oFRAME_READY, oWR_BANK, oRD_EMPTY);
    end
    iRD_REQ = 1;
    step();
    step();
    iRD_REQ = 0;
    checks++;
    if (oRD_VALID !== 1'b0 || oRD_BANK !== 2'd0 || oRD_USEDW !== 10'd0) begin
      failures++;
      $display("FAIL empty_read: valid=%0b rd_bank=%0d usedw=%0d, want 0 0 0", oRD_VALID, oRD_BANK, oRD_USEDW);
    end
    write_word(16'h5000, 1'b1, 1'b1);
    checks++;
    if (oWR_BANK !== 2'd1 || oFRAME_READY !== 1'b1) begin
      failures++;
      $display("FAIL empty_then_commit: wr_bank=%0d ready=%0b, want 1 1", oWR_BANK, oFRAME_READY);
    end
    read_word("empty");
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    write_frame(16'h6000, 6);
    step();
    for (int i = 0; i < 3; i++) read_word("middrain");
    iRST = 1;
    #2;
    checks++;
    if ({oWR_FULL, oWR_BANK, oDATA, oRD_VALID, oRD_EMPTY, oRD_BANK, oRD_USEDW, oFRAME_READY, oOVERRUN_CNT} !== rst_exp) begin
      failures++;
      $display("FAIL middrain_async_reset: got %h want %h",
        {oWR_FULL, oWR_BANK, oDATA, oRD_VALID, oRD_EMPTY, oRD_BANK, oRD_USEDW, oFRAME_READY, oOVERRUN_CNT}, rst_exp);
    end
    step();
    iRST = 0;
    exp_q.delete();
    step();
    write_frame(16'h6100, 2);
    checks++;
    if (oWR_BANK !== 2'd1 || oRD_BANK !== 2'd0 || oRD_USEDW !== 10'd2) begin
      failures++;
      $display("FAIL middrain_next_frame: wr_bank=%0d rd_bank=%0d usedw=%0d, want 1 0 2", oWR_BANK, oRD_BANK, oRD_USEDW);
    end
    for (int i = 0; i < 2; i++) read_word("after_reset");
  endtask

  initial begin
    rst_exp = {1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 2'd0, 10'd0, 1'b0, 16'h0000};
    idle_inputs();
    test_reset();
    test_basic_frame();
    test_four_banks();
    test_full_bank();
    test_abort();
    test_empty_ops();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
